pmu_readout_serializer: RTL and testbench
=========================================

// Module: pmu_readout_serializer
// PURPOSE
//  Sits between the per-core PMU read ports of mesh_with_loaders and the UART TX byte path in the cosim top.
//  Accepts one read request (core index + PMU counter address) and drives that core's pmu_addr.
//  Captures the 64-bit counter after a fixed read latency, then streams it as 8 bytes, LSB first.
//  Decouples the uart_control command FSM from PMU timing and byte pacing.
// PARAMETERS
//  CORE_COUNT    16  number of cores / PMU read ports
//  PMU_ADDR_W    5   PMU counter address width
//  PMU_DATA_W    64  PMU counter width; must be a multiple of 8
//  READ_LATENCY  1   cycles from pmu_addr_o change to valid pmu_data_i (>=1)
// PORTS
//  clk_i         in   1                        clock
//  arstn_i       in   1                        synchronous active-low reset
//  req_valid_i   in   1                        read request valid
//  req_ready_o   out  1                        block can accept a request
//  req_core_i    in   $clog2(CORE_COUNT)       target core index
//  req_addr_i    in   PMU_ADDR_W               PMU counter address
//  pmu_addr_o    out  PMU_ADDR_W x CORE_COUNT  per-core PMU address (unpacked array)
//  pmu_data_i    in   PMU_DATA_W x CORE_COUNT  per-core PMU data (unpacked array)
//  byte_valid_o  out  1                        output byte valid
//  byte_ready_i  in   1                        TX accepts byte
//  byte_data_o   out  8                        output byte
//  busy_o        out  1                        transaction in flight (state != IDLE)
// BEHAVIOUR
//  Reset (arstn_i low at a clk_i edge): state=IDLE.
//   All pmu_addr_o=0. byte_valid_o=0. byte_data_o=0. busy_o=0. req_ready_o=1 in the first cycle after reset.
//  Reset mid-transaction aborts it. The partial byte stream is dropped and no further bytes are issued.
//  FSM states: IDLE -> WAIT -> SEND -> IDLE.
//  IDLE:
//   - req_ready_o=1. On req_valid_i&&req_ready_o, latch core and addr.
//   - Set pmu_addr_o[core]=addr; every other pmu_addr_o stays 0. Load wait counter=READ_LATENCY. Go to WAIT.
//  WAIT:
//   - req_ready_o=0. Decrement the counter each cycle.
//   - In the cycle the counter reads 1, capture pmu_data_i[core] into the shift register, byte index=0, go to SEND.
//   - With READ_LATENCY=1, capture happens in the first cycle after acceptance.
//  SEND:
//   - byte_valid_o=1, byte_data_o=shreg[7:0].
//   - On byte_valid_o&&byte_ready_i: shift shreg right by 8 and increment the index.
//   - After byte PMU_DATA_W/8-1 is accepted, go to IDLE: byte_valid_o=0, pmu_addr_o all 0.
//  byte_data_o and byte_valid_o are stable while byte_valid_o=1 and byte_ready_i=0 (AXI-S style hold).
//  pmu_addr_o[core] is held from acceptance until the return to IDLE.
//  Out-of-range core index (req_core_i >= CORE_COUNT): the request is still accepted and timing is unchanged.
//   - No pmu_addr_o is driven.
//   - The captured value is all ones (8 bytes of 0xFF).
//  Back-to-back: a new request is accepted no earlier than the cycle after the last byte handshake (req_ready_o=1 in IDLE).
//  Minimum transaction: 1 + READ_LATENCY + PMU_DATA_W/8 cycles when byte_ready_i is held at 1.
//  Byte index counter width is $clog2(PMU_DATA_W/8); it must not wrap before the final byte.
//  busy_o=1 in WAIT and SEND, 0 in IDLE.
//  req_valid_i asserted during WAIT or SEND is ignored and not queued.
// TESTING
//  1 Reset: hold arstn_i low for 3 clk_i -> byte_valid_o=0, busy_o=0, all pmu_addr_o=0, req_ready_o=1 after release.
//  2 Basic read: core 3, addr 5, pmu_data_i[3]=64'h0123_4567_89AB_CDEF, byte_ready_i=1
//     -> bytes EF,CD,AB,89,67,45,23,01 on consecutive cycles; pmu_addr_o[3]=5 throughout; total 10 cycles.
//  3 Backpressure: same read with byte_ready_i toggling 1,0,0,1,...
//     -> byte_data_o held stable while stalled; all 8 bytes arrive in order with no duplicates.
//  4 READ_LATENCY=3: pmu_data_i changes from A to B 2 cycles after acceptance, 3-cycle model -> captured value is B, not A.
//  5 Mid-send reset: assert arstn_i after the 4th byte -> byte_valid_o=0 next cycle, no further bytes; a new request then succeeds.
//  6 Out-of-range/overlap: CORE_COUNT=12, req_core_i=13 -> 8 x 0xFF, pmu_addr_o all 0;
//     req_valid_i pulsed during SEND -> ignored, no extra bytes.

Source files
------------

// File: rtl/pmu_readout_serializer.sv
// Reads one 64-bit PMU counter from a selected core and streams it out as bytes, LSB first.
// Handshakes are valid/ready on both sides; the byte stream holds steady under backpressure.
module pmu_readout_serializer #(
  parameter int CORE_COUNT   = 16,
  parameter int PMU_ADDR_W   = 5,
  parameter int PMU_DATA_W   = 64,
  parameter int READ_LATENCY = 1,
  localparam int CORE_W      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CORE_W-1:0]     req_core_i,
  input  logic [PMU_ADDR_W-1:0] req_addr_i,
  output logic [PMU_ADDR_W-1:0] pmu_addr_o [CORE_COUNT],
  input  logic [PMU_DATA_W-1:0] pmu_data_i [CORE_COUNT],
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic [7:0]            byte_data_o,
  output logic                  busy_o
);

  localparam int NBYTES = PMU_DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(READ_LATENCY + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND
  } state_t;

  state_t                state, state_nxt;
  logic [CORE_W-1:0]     core_q;
  logic [PMU_ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [PMU_DATA_W-1:0] shreg_q;
  logic [PMU_DATA_W-1:0] sel_data;

  logic accept;
  logic capture;
  logic byte_fire;
  logic last_byte;

  assign req_ready_o  = (state == ST_IDLE);
  assign busy_o       = (state != ST_IDLE);
  assign byte_valid_o = (state == ST_SEND);
  assign byte_data_o  = byte_valid_o ? shreg_q[7:0] : 8'h00;

  assign accept    = req_valid_i && req_ready_o;
  assign capture   = (state == ST_WAIT) && (cnt_q == CNT_ONE);
  assign byte_fire = byte_valid_o && byte_ready_i;
  assign last_byte = byte_fire && (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept)    state_nxt = ST_WAIT;
      ST_WAIT: if (capture)   state_nxt = ST_SEND;
      ST_SEND: if (last_byte) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // An index outside the core range selects nothing, so the captured word is all ones.
  always_comb begin
    sel_data = '1;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (core_q == CORE_W'(i)) sel_data = pmu_data_i[i];
    end
  end

  // Only the addressed core sees a non-zero address, and only while a transaction is open.
  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      pmu_addr_o[i] = (busy_o && (core_q == CORE_W'(i))) ? addr_q : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!arstn_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      core_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      if (accept) begin
        core_q <= req_core_i;
        addr_q <= req_addr_i;
        cnt_q  <= LAT_INIT;
      end else if (state == ST_WAIT) begin
        cnt_q <= cnt_q - CNT_ONE;
      end

      if (capture) begin
        shreg_q <= sel_data;
        idx_q   <= '0;
      end else if (byte_fire) begin
        shreg_q <= shreg_q >> 8;
        idx_q   <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pmu_readout_serializer.sv
// Scoreboard bench: requests push expected bytes, negedge monitors pop and compare on each handshake.
// A second instance with a 3-cycle read latency checks the capture point.
module tb_pmu_readout_serializer;

  localparam int NC   = 12;
  localparam int NC_B = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // instance A: 12 cores, latency 1
  logic          req_valid, req_ready, byte_valid, byte_ready, busy;
  logic [3:0]    req_core;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] pmu_addr [NC];
  logic [DW-1:0] pmu_data [NC];
  logic [7:0]    byte_data;

  // instance B: 4 cores, latency 3
  logic          req_valid_b, req_ready_b, byte_valid_b, byte_ready_b, busy_b;
  logic [1:0]    req_core_b;
  logic [AW-1:0] req_addr_b;
  logic [AW-1:0] pmu_addr_b [NC_B];
  logic [DW-1:0] pmu_data_b [NC_B];
  logic [7:0]    byte_data_b;

  pmu_readout_serializer #(.CORE_COUNT(NC), .PMU_ADDR_W(AW), .PMU_DATA_W(DW), .READ_LATENCY(1)) u_dut (
    .clk_i(clk), .arstn_i(arstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_core_i(req_core), .req_addr_i(req_addr),
    .pmu_addr_o(pmu_addr), .pmu_data_i(pmu_data),
    .byte_valid_o(byte_valid), .byte_ready_i(byte_ready), .byte_data_o(byte_data), .busy_o(busy)
  );

  pmu_readout_serializer #(.CORE_COUNT(NC_B), .PMU_ADDR_W(AW), .PMU_DATA_W(DW), .READ_LATENCY(3)) u_dut_lat3 (
    .clk_i(clk), .arstn_i(arstn),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_core_i(req_core_b), .req_addr_i(req_addr_b),
    .pmu_addr_o(pmu_addr_b), .pmu_data_i(pmu_data_b),
    .byte_valid_o(byte_valid_b), .byte_ready_i(byte_ready_b), .byte_data_o(byte_data_b), .busy_o(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0]    exp_q [$];
  logic [7:0]    expb_q [$];
  logic [AW-1:0] exp_addr [NC];
  int rx_count = 0;
  int last_rx_cyc = 0;
  int accept_cyc = 0;

  function automatic logic addr_bad();
    logic bad = 1'b0;
    for (int i = 0; i < NC; i++) if (pmu_addr[i] !== exp_addr[i]) bad = 1'b1;
    return bad;
  endfunction

  // monitor A: hold check under stall, byte order, address held during the stream
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (stalled) begin
      check("hold_valid", byte_valid, 1);
      check("hold_data", byte_data, held);
    end
    stalled = byte_valid && !byte_ready && arstn;
    held    = byte_data;
    if (byte_valid && byte_ready && arstn) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %0h expected no byte (t=%0t)", byte_data, $time);
      end else begin
        check("byte", byte_data, exp_q.pop_front());
        check("pmu_addr_hold", addr_bad(), 0);
      end
      rx_count++;
      last_rx_cyc = cyc;
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (byte_valid_b && byte_ready_b && arstn) begin
      if (expb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte_lat3: got %0h expected no byte (t=%0t)", byte_data_b, $time);
      end else begin
        check("byte_lat3", byte_data_b, expb_q.pop_front());
      end
    end
  end

  task automatic req_a(input logic [3:0] core, input logic [AW-1:0] addr, input logic [63:0] val);
    logic ok = 1'b0;
    for (int i = 0; i < NC; i++) exp_addr[i] = '0;
    if (int'(core) < NC) exp_addr[core] = addr;
    for (int b = 0; b < 8; b++) exp_q.push_back(val[8*b +: 8]);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_core  = core;
    req_addr  = addr;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_accepted", ok, 1);
    accept_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pmu_addr_drive", addr_bad(), 0);
    check("busy_in_txn", busy, 1);
  endtask

  task automatic wait_idle_a(input int budget);
    logic done = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_a", done, 1);
    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_ready", req_ready, 1);
  endtask

  logic [3:0] pat = 4'b1001;
  int base;

  initial begin
    req_valid = 1'b0; req_core = '0; req_addr = '0; byte_ready = 1'b1;
    req_valid_b = 1'b0; req_core_b = '0; req_addr_b = '0; byte_ready_b = 1'b1;
    for (int i = 0; i < NC; i++) begin
      pmu_data[i] = {8{8'(8'h10 + i)}};
      exp_addr[i] = '0;
    end
    for (int i = 0; i < NC_B; i++) pmu_data_b[i] = '0;

    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", byte_data, 0);
    check("rst_pmu_addr", addr_bad(), 0);
    arstn = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready, 1);

    // basic read, timing
    pmu_data[3] = 64'h0123_4567_89AB_CDEF;
    base = rx_count;
    req_a(4'd3, 5'd5, 64'h0123_4567_89AB_CDEF);
    wait_idle_a(40);
    check("basic_count", rx_count - base, 8);
    check("basic_cycles", last_rx_cyc - accept_cyc, 9);

    // boundary cores
    req_a(4'd11, 5'd31, pmu_data[11]);
    wait_idle_a(40);
    req_a(4'd0, 5'd1, pmu_data[0]);
    wait_idle_a(40);

    // backpressure 1,0,0,1,...
    base = rx_count;
    req_a(4'd3, 5'd5, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      byte_ready = pat[i % 4];
      if (exp_q.size() == 0 && !busy) break;
    end
    byte_ready = 1'b1;
    wait_idle_a(40);
    check("bp_count", rx_count - base, 8);

    // reset after the 4th byte
    base = rx_count;
    req_a(4'd7, 5'd9, pmu_data[7]);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_count == base + 4) break;
    end
    check("midrst_progress", rx_count - base, 4);
    arstn = 1'b0;
    byte_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_valid", byte_valid, 0);
    check("midrst_busy", busy, 0);
    byte_ready = 1'b1;
    @(posedge clk); #1;
    arstn = 1'b1;
    for (int i = 0; i < NC; i++) exp_addr[i] = '0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_bytes", rx_count - base, 4);
    req_a(4'd2, 5'd4, pmu_data[2]);
    wait_idle_a(40);

    // out-of-range cores, overlapping request ignored
    req_a(4'd12, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle_a(40);
    base = rx_count;
    req_a(4'd13, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    req_valid = 1'b1; req_core = 4'd1; req_addr = 5'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle_a(40);
    check("overlap_count", rx_count - base, 8);

    // latency 3: data changes A->B two cycles after acceptance
    begin
      logic ok = 1'b0;
      logic [63:0] val_b = 64'h1122_3344_5566_7788;
      pmu_data_b[1] = 64'hAAAA_AAAA_AAAA_AAAA;
      for (int b = 0; b < 8; b++) expb_q.push_back(val_b[8*b +: 8]);
      @(posedge clk); #1;
      req_valid_b = 1'b1; req_core_b = 2'd1; req_addr_b = 5'd3;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (req_ready_b) begin
          ok = 1'b1;
          break;
        end
      end
      check("lat3_accepted", ok, 1);
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      check("lat3_pmu_addr", pmu_addr_b[1], 3);
      @(posedge clk); #1;
      pmu_data_b[1] = val_b;
      check("lat3_busy", busy_b, 1);
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(posedge clk); #1;
        if (expb_q.size() == 0 && !busy_b) begin
          ok = 1'b1;
          break;
        end
      end
      check("drain_lat3", ok, 1);
      check("lat3_addr_clear", pmu_addr_b[1], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
